// File: rtl/store_buffer.sv
// store_buffer: in-order store queue between the pipeline and memory.
// Each accepted store is lane-aligned at accept time (byte enables plus
// shifted data) and held in a DEPTH-entry FIFO until memory takes it.
// Compile-time option: define STORE_MISALIGN_TRAP_EN to reject misaligned
// stores with an err pulse; otherwise the lane offset is rounded down to
// the store size and the store is queued normally.
module store_buffer #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_funct3,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [XLEN-1:0]            in_data,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [XLEN-1:0]            mem_data,
  output logic [XLEN/8-1:0]          mem_be,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [XLEN-1:0]   r_data [DEPTH];
  logic [NB-1:0]     r_be   [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_err;

  logic [OFFW-1:0]   w_off;
  logic [OFFW-1:0]   w_off_al;
  logic [3:0]        w_szm1;
  logic [NB-1:0]     w_bmask;
  logic [XLEN-1:0]   w_dmask;
  logic              w_illegal;
  logic              w_misaligned;
  logic              w_reject;
  logic              w_hs;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_al_addr;
  logic [XLEN-1:0]   w_al_data;
  logic [NB-1:0]     w_al_be;

  assign w_off = in_addr[OFFW-1:0];

  // Decode store size into an unshifted lane mask and flag illegal sizes.
  always_comb begin
    w_illegal = 1'b0;
    w_bmask   = '0;
    w_szm1    = '0;
    case (in_funct3)
      3'b000: begin w_bmask = NB'(8'h01); w_szm1 = 4'd0; end
      3'b001: begin w_bmask = NB'(8'h03); w_szm1 = 4'd1; end
      3'b010: begin w_bmask = NB'(8'h0F); w_szm1 = 4'd3; end
      3'b011: begin
        if (XLEN == 64) begin
          w_bmask = NB'(8'hFF);
          w_szm1  = 4'd7;
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Expand the lane mask to a bit mask and build the aligned entry.
  always_comb begin
    w_dmask = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      w_dmask[i*8 +: 8] = {8{w_bmask[i]}};
    end
    w_misaligned = (w_off & OFFW'(w_szm1)) != '0;
    w_off_al     = w_off & ~OFFW'(w_szm1);
    w_al_be      = w_bmask << w_off_al;
    w_al_data    = (in_data & w_dmask) << {w_off_al, 3'b000};
    w_al_addr    = {in_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  end

`ifdef STORE_MISALIGN_TRAP_EN
  assign w_reject = w_illegal | w_misaligned;
`else
  assign w_reject = w_illegal;
`endif

  assign in_ready = (r_count != CW'(DEPTH));
  assign w_hs     = in_valid && in_ready;
  assign w_push   = w_hs && !w_reject;
  assign w_pop    = (r_count != '0) && mem_ready;

  // Queue storage, pointers, occupancy and the one-cycle reject pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_be[i]   <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_hs && w_reject;
      if (w_push) begin
        r_addr[r_wr_ptr] <= w_al_addr;
        r_data[r_wr_ptr] <= w_al_data;
        r_be[r_wr_ptr]   <= w_al_be;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign count     = r_count;
  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign mem_valid = !empty;
  assign mem_addr  = r_addr[r_rd_ptr];
  assign mem_data  = r_data[r_rd_ptr];
  assign mem_be    = r_be[r_rd_ptr];
  assign err       = r_err;

endmodule
